// File: rtl/alu_op_sequencer_if.sv
// Request/response and ALU-control bundle between the CPU/microcode layer,
// the alu_op_sequencer and the shared external 16-bit Hack ALU.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zr;
    logic             rsp_ng;

    logic [WIDTH-1:0] alu_x;
    logic [WIDTH-1:0] alu_y;
    logic             alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zr;
    logic             alu_ng;

    // sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_zr, alu_ng,
        output req_ready, rsp_valid, rsp_result, rsp_zr, rsp_ng,
        output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
    );

    // requester/ALU side
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_zr, alu_ng,
        input  req_ready, rsp_valid, rsp_result, rsp_zr, rsp_ng,
        input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Front end sharing one Hack ALU for ADD/SUB/AND (1 cycle) and shift-add MUL.
// Optional macro ALU_SEQ_MUL_EARLY_EXIT_EN: MUL stops once the multiplier runs out of set bits.
module alu_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           r_state, w_next;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_result;
    logic             r_zr, r_ng;

    logic             w_mul_done;
    logic [5:0]       w_ctrl;
    logic [WIDTH-1:0] w_x, w_y;

`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
    // Remaining multiplier bits all zero means every later step adds nothing.
    assign w_mul_done = ((r_mplier >> 1) == '0) || (r_count == LAST_ITER);
`else
    assign w_mul_done = (r_count == LAST_ITER);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.req_valid) w_next = (bus.req_op == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC: w_next = S_RESP;
            S_MUL:  if (w_mul_done) w_next = S_RESP;
            S_RESP: if (bus.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ALU drive; control order is {zx,nx,zy,ny,f,no}
    always_comb begin
        w_x    = '0;
        w_y    = '0;
        w_ctrl = 6'b000000;
        case (r_state)
            S_EXEC: begin
                w_x = r_mcand;
                w_y = r_mplier;
                case (r_op)
                    OP_ADD:  w_ctrl = 6'b000010;
                    OP_SUB:  w_ctrl = 6'b010011;
                    OP_AND:  w_ctrl = 6'b000000;
                    default: w_ctrl = 6'b000000;
                endcase
            end
            S_MUL: begin
                // zeroing y when the multiplier bit is clear turns the add into a pass of acc
                w_x    = r_acc;
                w_y    = r_mcand;
                w_ctrl = {2'b00, ~r_mplier[0], 3'b010};
            end
            default: ;
        endcase
    end

    // Operands for EXEC share the mcand/mplier registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_zr     <= 1'b0;
            r_ng     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_op     <= bus.req_op;
                    r_acc    <= '0;
                    r_mcand  <= bus.req_a;
                    r_mplier <= bus.req_b;
                    r_count  <= '0;
                end
                S_EXEC: begin
                    r_result <= bus.alu_out;
                    r_zr     <= bus.alu_zr;
                    r_ng     <= bus.alu_ng;
                end
                S_MUL: begin
                    r_acc    <= bus.alu_out;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (w_mul_done) begin
                        r_result <= bus.alu_out;
                        r_zr     <= bus.alu_zr;
                        r_ng     <= bus.alu_ng;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_result = r_result;
    assign bus.rsp_zr     = r_zr;
    assign bus.rsp_ng     = r_ng;
    assign bus.alu_x      = w_x;
    assign bus.alu_y      = w_y;
    assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = w_ctrl;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural Hack ALU and a result scoreboard.
module tb_alu_op_sequencer;
    typedef struct packed {
        logic [15:0] res;
        logic        zr;
        logic        ng;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    alu_op_sequencer_if #(.WIDTH(16)) bus ();

    alu_op_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // external Hack ALU
    logic [15:0] ax, ay, ao;
    always_comb begin
        ax = bus.alu_zx ? 16'h0 : bus.alu_x;
        if (bus.alu_nx) ax = ~ax;
        ay = bus.alu_zy ? 16'h0 : bus.alu_y;
        if (bus.alu_ny) ay = ~ay;
        ao = bus.alu_f ? (ax + ay) : (ax & ay);
        if (bus.alu_no) ao = ~ao;
    end
    assign bus.alu_out = ao;
    assign bus.alu_zr  = (ao == 16'h0);
    assign bus.alu_ng  = ao[15];

    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        exp_t e;
        p = 32'(a) * 32'(b);
        case (op)
            2'b00:   e.res = a + b;
            2'b01:   e.res = a - b;
            2'b10:   e.res = a & b;
            default: e.res = p[15:0];
        endcase
        e.zr = (e.res == 16'h0);
        e.ng = e.res[15];
        return e;
    endfunction

    function automatic logic [5:0] ctrl_of(input logic [1:0] op, input logic [15:0] b);
        case (op)
            2'b00:   return 6'b000010;
            2'b01:   return 6'b010011;
            2'b10:   return 6'b000000;
            default: return {2'b00, ~b[0], 3'b010};
        endcase
    endfunction

    function automatic int mul_lat(input logic [15:0] b);
`ifdef ALU_SEQ_MUL_EARLY_EXIT_EN
        for (int i = 15; i >= 0; i--) if (b[i]) return i + 1;
        return 1;
`else
        return 16;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        int w = 0;
        while (!bus.req_ready && w < 50) begin tick(); w++; end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        tick();
        bus.req_valid = 1'b0;
        bus.req_a     = 16'($urandom);
        bus.req_b     = 16'($urandom);
        exp_q.push_back(model(op, a, b));
        chk("alu_ctrl", 32'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}),
            32'(ctrl_of(op, b)));
        chk("alu_x", 32'(bus.alu_x), (op == 2'b11) ? 32'd0 : 32'(a));
        chk("alu_y", 32'(bus.alu_y), (op == 2'b11) ? 32'(a) : 32'(b));
    endtask

    task automatic wait_rsp(input int exp_lat);
        int   cyc = 0;
        exp_t e;
        while (!bus.rsp_valid && cyc < 40) begin tick(); cyc++; end
        chk("latency", 32'(cyc), 32'(exp_lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
        chk("rsp_zr", 32'(bus.rsp_zr), 32'(e.zr));
        chk("rsp_ng", 32'(bus.rsp_ng), 32'(e.ng));
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
        chk("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic stray;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = 16'h0;
        bus.req_b     = 16'h0;
        bus.rsp_ready = 1'b0;

        repeat (2) tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_bits", 32'({bus.rsp_result, bus.rsp_zr, bus.rsp_ng}), 32'd0);
        chk("rst_alu_xy", {bus.alu_x, bus.alu_y}, 32'd0);
        reset = 1'b0;
        tick();

        // rsp_ready without a response does nothing
        bus.rsp_ready = 1'b1;
        repeat (2) tick();
        bus.rsp_ready = 1'b0;
        chk("idle_rsp_ready_noeffect", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);

        do_req(2'b00, 16'd10, 16'd5);   wait_rsp(1); consume();
        do_req(2'b01, 16'd5, 16'd10);   wait_rsp(1); consume();
        do_req(2'b01, 16'd7, 16'd7);    wait_rsp(1); consume();

        // AND with a stalled consumer and a competing request
        do_req(2'b10, 16'hAAAA, 16'hCCCC); wait_rsp(1);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_a     = 16'h1;
        bus.req_b     = 16'h1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_state", 32'({bus.rsp_valid, bus.req_ready, bus.rsp_result}), 32'({2'b10, 16'h8888}));
        end
        bus.req_valid = 1'b0;
        consume();

        do_req(2'b11, 16'd300, 16'd7);     wait_rsp(mul_lat(16'd7));     consume();
        do_req(2'b11, 16'h0100, 16'h0100); wait_rsp(mul_lat(16'h0100));  consume();
        do_req(2'b11, 16'hFFFF, 16'd3);    wait_rsp(mul_lat(16'd3));     consume();
        do_req(2'b11, 16'h1234, 16'h0);    wait_rsp(mul_lat(16'h0));     consume();

        // back-to-back: second request goes in right after the handshake
        do_req(2'b00, 16'd1, 16'd2);       wait_rsp(1); consume();
        do_req(2'b00, 16'h7FFF, 16'h0001); wait_rsp(1); consume();

        // reset in the middle of a full-length multiply
        do_req(2'b11, 16'd3, 16'h8001);
        repeat (7) tick();
        reset = 1'b1;
        #1;
        chk("midrst_ready_valid", 32'({bus.req_ready, bus.rsp_valid}), 32'b10);
        chk("midrst_alu_xy", {bus.alu_x, bus.alu_y}, 32'd0);
        chk("midrst_ctrl", 32'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}), 32'd0);
        chk("midrst_rsp_bits", 32'({bus.rsp_result, bus.rsp_zr, bus.rsp_ng}), 32'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        tick();
        reset = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.rsp_valid) stray = 1'b1;
        end
        chk("no_rsp_after_reset", 32'(stray), 32'd0);
        do_req(2'b11, 16'd123, 16'd45); wait_rsp(mul_lat(16'd45)); consume();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
